// File: rtl/immediate_pipe.sv
// immediate_pipe: decode-stage immediate generator (RV32/RV64, CSR zimm)
// behind a valid/ready handshake, with a two-entry skid buffer and flush.
module immediate_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [2:0]      immediate_select,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic            illegal
);

    // Only RV32 and RV64 immediate widths are meaningful.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immediate_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_I   = 3'b001;
    localparam logic [2:0] SEL_S   = 3'b010;
    localparam logic [2:0] SEL_B   = 3'b011;
    localparam logic [2:0] SEL_U   = 3'b100;
    localparam logic [2:0] SEL_J   = 3'b101;
    localparam logic [2:0] SEL_CSR = 3'b110;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] imm;
    } entry_t;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        load_main;
    logic        load_skid;
    logic        skid_to_main;
    logic        accept;
    logic        drain;
    logic [31:0] imm32;
    logic        zext;
    logic        sel_illegal;
    entry_t      new_entry;
    entry_t      skid;
    logic        unused_opcode;

    // The opcode field carries no immediate bits.
    assign unused_opcode = ^instruction[6:0];

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Decode the selected format into a 32-bit pattern plus extension kind.
    always_comb begin
        imm32       = '0;
        zext        = 1'b0;
        sel_illegal = 1'b0;
        case (immediate_select)
            SEL_I:   imm32 = {{20{instruction[31]}}, instruction[31:20]};
            SEL_S:   imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            SEL_B:   imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            SEL_U:   imm32 = {instruction[31:12], 12'b0};
            SEL_J:   imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            SEL_CSR: begin
                imm32 = {27'b0, instruction[19:15]};
                zext  = 1'b1;
            end
            default: sel_illegal = 1'b1;
        endcase
    end

    // Widen to XLEN: CSR zimm is zero-extended, every other format sign-extended.
    always_comb begin
        new_entry.illegal = sel_illegal;
        if (zext) begin
            new_entry.imm = XLEN'(imm32);
        end else begin
            new_entry.imm = XLEN'($signed(imm32));
        end
    end

    // Occupancy next-state and buffer load steering; flush overrides everything.
    always_comb begin
        state_next   = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_next   = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next   = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Registered handshake outputs, decoded from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Main (output) register: holds until drained, then refilled from input or skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            immediate <= '0;
            illegal   <= 1'b0;
        end else if (load_main) begin
            immediate <= new_entry.imm;
            illegal   <= new_entry.illegal;
        end else if (skid_to_main) begin
            immediate <= skid.imm;
            illegal   <= skid.illegal;
        end
    end

    // Skid register: captures an input arriving while the main entry is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid <= '0;
        end else if (load_skid) begin
            skid <= new_entry;
        end
    end

endmodule

// File: tb/tb_immediate_pipe.sv
// tb_immediate_pipe: vector table, hand-written corner sequences and random
// traffic against a queue-based reference model, for XLEN=32 and XLEN=64.
module tb_immediate_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
    } ent_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic [2:0]  immediate_select;
    logic        out_ready;

    logic        ir32, ov32, ill32;
    logic [31:0] imm32;
    logic        ir64, ov64, ill64;
    logic [63:0] imm64;

    int n_pass  = 0;
    int n_total = 0;

    ent_t        q[$];
    logic [31:0] seen[$];
    bit          m_rdy     = 1'b0;
    bit          m_was_rst = 1'b0;

    immediate_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .instruction(instruction), .immediate_select(immediate_select),
        .out_valid(ov32), .out_ready(out_ready), .immediate(imm32), .illegal(ill32)
    );

    immediate_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .instruction(instruction), .immediate_select(immediate_select),
        .out_valid(ov64), .out_ready(out_ready), .immediate(imm64), .illegal(ill64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference immediate computed as signed integer arithmetic on the fields.
    function automatic ent_t ref_imm(logic [31:0] ins, logic [2:0] sel);
        ent_t        e;
        longint      v;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [4:0]  z5;
        e.ill = 1'b0;
        v     = 0;
        case (sel)
            3'd1: v = longint'($signed(ins[31:20]));
            3'd2: begin
                s12 = {ins[31:25], ins[11:7]};
                v   = longint'($signed(s12));
            end
            3'd3: begin
                b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v   = longint'($signed(b13));
            end
            3'd4: v = longint'($signed(ins[31:12])) * 64'sd4096;
            3'd5: begin
                j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v   = longint'($signed(j21));
            end
            3'd6: begin
                z5 = ins[19:15];
                v  = longint'(z5);
            end
            default: begin
                v     = 0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid32", 64'(ov32), 64'(q.size() != 0));
        chk("out_valid64", 64'(ov64), 64'(q.size() != 0));
        chk("in_ready32",  64'(ir32), 64'(m_rdy));
        chk("in_ready64",  64'(ir64), 64'(m_rdy));
        if (q.size() != 0) begin
            chk("imm32", 64'(imm32), {32'b0, q[0].imm[31:0]});
            chk("imm64", imm64, q[0].imm);
            chk("ill32", 64'(ill32), 64'(q[0].ill));
            chk("ill64", 64'(ill64), 64'(q[0].ill));
        end
        if (m_was_rst) begin
            chk("rst_imm32", 64'(imm32), 64'd0);
            chk("rst_imm64", imm64, 64'd0);
            chk("rst_ill",   64'(ill32 | ill64), 64'd0);
        end
    endtask

    // One clock: predict handshakes from the model, advance it, then compare.
    task automatic step();
        bit acc;
        bit drn;
        acc = in_valid && m_rdy;
        drn = (q.size() != 0) && out_ready;
        if (ov32 && out_ready) seen.push_back(imm32);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_rdy     = 1'b0;
            m_was_rst = 1'b1;
        end else begin
            m_was_rst = 1'b0;
            if (drn) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(ref_imm(instruction, immediate_select));
            m_rdy = (q.size() < 2);
        end
        #1;
        check_outputs();
    endtask

    vec_t        vt[10];
    logic [63:0] held_imm;
    logic        held_ill;

    initial begin
        vt[0] = '{32'hFFF00093, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1] = '{32'hFE000EE3, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[2] = '{32'h000F8073, 3'b110, 64'h0000_0000_0000_001F, 1'b0};
        vt[3] = '{32'hFFFFFFFF, 3'b111, 64'h0000_0000_0000_0000, 1'b1};
        vt[4] = '{32'h800000B7, 3'b100, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vt[5] = '{32'h7FF00093, 3'b001, 64'h0000_0000_0000_07FF, 1'b0};
        vt[6] = '{32'h12345678, 3'b000, 64'h0000_0000_0000_0000, 1'b1};
        vt[7] = '{32'hFE000FA3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[8] = '{32'h7FFFF06F, 3'b101, 64'h0000_0000_000F_FFFE, 1'b0};
        vt[9] = '{32'h12345037, 3'b100, 64'h0000_0000_1234_5000, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        instruction = 32'hFFF00093; immediate_select = 3'b001;

        // Reset held three cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_out_valid", 64'(ov32 | ov64), 64'd0);
            chk("reset_in_ready",  64'(ir32 | ir64), 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("release_in_ready", 64'(ir32 & ir64), 64'd1);

        // Format vectors, one cycle latency, out_ready high.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; instruction = vt[i].ins; immediate_select = vt[i].sel;
            step();
            in_valid = 1'b0;
            chk("vec_out_valid", 64'(ov32 & ov64), 64'd1);
            chk("vec_imm64", imm64, vt[i].imm);
            chk("vec_imm32", 64'(imm32), {32'b0, vt[i].imm[31:0]});
            chk("vec_illegal", 64'(ill64), 64'(vt[i].ill));
            step();
        end

        // Backpressure: A and B accepted, C held until space frees.
        seen.delete();
        out_ready = 1'b0; in_valid = 1'b1; immediate_select = 3'b001;
        instruction = 32'h00100093; step();
        instruction = 32'h00200093; step();
        instruction = 32'h00300093; step();
        chk("bp_in_ready_low", 64'(ir32), 64'd0);
        step();
        chk("bp_still_full", 64'(ir32), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("bp_order_a", 64'(seen[0]), 64'd1);
            chk("bp_order_b", 64'(seen[1]), 64'd2);
            chk("bp_order_c", 64'(seen[2]), 64'd3);
        end

        // Stability: stalled output holds while inputs toggle.
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'h80000013; immediate_select = 3'b001;
        step();
        held_imm = imm64; held_ill = ill64;
        chk("stab_captured", held_imm, 64'hFFFF_FFFF_FFFF_F800);
        for (int i = 0; i < 5; i++) begin
            instruction = $urandom; immediate_select = 3'($urandom_range(0, 7));
            step();
            chk("stab_imm", imm64, held_imm);
            chk("stab_ill", 64'(ill64), 64'(held_ill));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Flush with two entries buffered and a new input in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; immediate_select = 3'b001;
        instruction = 32'h00D00093; step();
        instruction = 32'h00E00093; step();
        instruction = 32'h00F00093; flush = 1'b1;
        seen.delete();
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(ov32 | ov64), 64'd0);
        chk("flush_in_ready",  64'(ir32 & ir64), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("flush_nothing_out", 64'(seen.size()), 64'd0);

        // Random traffic against the model, with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            in_valid         = ($urandom_range(0, 3) != 0);
            out_ready        = ($urandom_range(0, 2) != 0);
            flush            = ($urandom_range(0, 31) == 0);
            rst              = ($urandom_range(0, 199) == 0);
            instruction      = $urandom;
            immediate_select = 3'($urandom_range(0, 7));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
